// File: rtl/prime_query_master.sv
// Initiator for the prime-finder responder: sweeps base, base+step, ... one query
// at a time, reports each result and tracks the widest prime gap seen.
module prime_query_master #(
    parameter int unsigned TIMEOUT_CYC = 4095,
    parameter int unsigned MAX_IN      = 9999,
    parameter int unsigned MIN_IN      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] base,
    input  logic [7:0]  step,
    input  logic [7:0]  count,
    output logic        give_valid,
    output logic [13:0] Intake,
    input  logic [13:0] UpPrime,
    input  logic [13:0] LowPrime,
    input  logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        result_valid,
    output logic [13:0] res_intake,
    output logic [13:0] res_up,
    output logic [13:0] res_low,
    output logic [13:0] res_gap,
    output logic [13:0] max_gap,
    output logic [13:0] max_gap_intake,
    output logic [7:0]  n_done,
    output logic        timeout_err,
    output logic        range_err
);

    localparam int unsigned DW = 14;
    localparam int unsigned CW = 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DW-1:0] MIN_V   = DW'(MIN_IN);
    localparam logic [DW-1:0] MAX_V   = DW'(MAX_IN);
    localparam logic [DW:0]   MAX_SUM = (DW+1)'(MAX_IN);
    localparam logic [TW-1:0] TO_V    = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RECORD,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] step_r, step_n;
    logic [CW-1:0] count_r, count_n;
    logic [TW-1:0] wait_cnt, wait_cnt_n;
    logic [TW-1:0] cnt_inc;
    logic [DW:0]   next_sum;

    logic          give_valid_n, busy_n, done_n, result_valid_n;
    logic [DW-1:0] intake_n, res_intake_n, res_up_n, res_low_n, res_gap_n;
    logic [DW-1:0] max_gap_n, max_gap_intake_n;
    logic [CW-1:0] n_done_n;
    logic          timeout_err_n, range_err_n;

    // 15-bit sum so the next query can never wrap back into range
    assign next_sum = {1'b0, Intake} + (DW+1)'(step_r);
    assign cnt_inc  = wait_cnt + TW'(1);

    always_comb begin
        state_n          = state;
        intake_n         = Intake;
        step_n           = step_r;
        count_n          = count_r;
        wait_cnt_n       = wait_cnt;
        res_intake_n     = res_intake;
        res_up_n         = res_up;
        res_low_n        = res_low;
        res_gap_n        = res_gap;
        max_gap_n        = max_gap;
        max_gap_intake_n = max_gap_intake;
        n_done_n         = n_done;
        timeout_err_n    = timeout_err;
        range_err_n      = range_err;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    step_n           = step;
                    count_n          = count;
                    max_gap_n        = '0;
                    max_gap_intake_n = '0;
                    n_done_n         = '0;
                    timeout_err_n    = 1'b0;
                    range_err_n      = 1'b0;
                    if (count == '0) begin
                        state_n = S_DONE;
                    end else if (base < MIN_V || base > MAX_V) begin
                        range_err_n = 1'b1;
                        state_n     = S_DONE;
                    end else begin
                        intake_n = base;
                        state_n  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_n = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (out_valid) begin
                    res_intake_n = Intake;
                    res_up_n     = UpPrime;
                    res_low_n    = LowPrime;
                    res_gap_n    = UpPrime - LowPrime;
                    n_done_n     = n_done + CW'(1);
                    state_n      = S_RECORD;
                end else begin
                    wait_cnt_n = cnt_inc;
                    if (cnt_inc == TO_V) begin
                        timeout_err_n = 1'b1;
                        state_n       = S_DONE;
                    end
                end
            end
            S_RECORD: begin
                // strict compare keeps the earliest query on a tie
                if (res_gap > max_gap) begin
                    max_gap_n        = res_gap;
                    max_gap_intake_n = res_intake;
                end
                if (n_done == count_r) begin
                    state_n = S_DONE;
                end else if (next_sum > MAX_SUM) begin
                    range_err_n = 1'b1;
                    state_n     = S_DONE;
                end else begin
                    intake_n = next_sum[DW-1:0];
                    state_n  = S_ISSUE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        give_valid_n   = (state_n == S_ISSUE);
        result_valid_n = (state_n == S_RECORD);
        busy_n         = (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_RECORD);
        done_n         = (state_n == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            step_r         <= '0;
            count_r        <= '0;
            wait_cnt       <= '0;
            give_valid     <= 1'b0;
            Intake         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            res_intake     <= '0;
            res_up         <= '0;
            res_low        <= '0;
            res_gap        <= '0;
            max_gap        <= '0;
            max_gap_intake <= '0;
            n_done         <= '0;
            timeout_err    <= 1'b0;
            range_err      <= 1'b0;
        end else begin
            state          <= state_n;
            step_r         <= step_n;
            count_r        <= count_n;
            wait_cnt       <= wait_cnt_n;
            give_valid     <= give_valid_n;
            Intake         <= intake_n;
            busy           <= busy_n;
            done           <= done_n;
            result_valid   <= result_valid_n;
            res_intake     <= res_intake_n;
            res_up         <= res_up_n;
            res_low        <= res_low_n;
            res_gap        <= res_gap_n;
            max_gap        <= max_gap_n;
            max_gap_intake <= max_gap_intake_n;
            n_done         <= n_done_n;
            timeout_err    <= timeout_err_n;
            range_err      <= range_err_n;
        end
    end

endmodule

// File: doc/prime_query_master.md
# prime_query_master

Initiator side of the prime-finder request/response interface: drives `give_valid`/`Intake` into a prime-finder responder and consumes `UpPrime`/`LowPrime`/`out_valid`. On `start` it issues a sweep of `count` queries (`base`, `base+step`, …), one outstanding at a time. It reports each result and tracks the widest prime gap seen. It sits between the lab control/test logic and the prime-finder datapath, and aborts the sweep on a responder timeout or an out-of-range query.

## Interface
- `TIMEOUT_CYC`, 4095: maximum WAIT cycles before abort.
- `MAX_IN`, 9999: largest legal `Intake`.
- `MIN_IN`, 3: smallest legal `Intake` (a lower prime must exist).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: begin sweep; sampled only in IDLE or DONE.
- `base` input 14: first query value; captured on `start`.
- `step` input 8: increment between queries; captured on `start`.
- `count` input 8: number of queries; captured on `start`; 0 is legal.
- `give_valid` output 1: one-cycle request pulse to responder.
- `Intake` output 14: query value; stable from `give_valid` until `out_valid` is sampled.
- `UpPrime` input 14: responder's smallest prime greater than `Intake`.
- `LowPrime` input 14: responder's largest prime less than `Intake`.
- `out_valid` input 1: responder result valid.
- `busy` output 1: high in ISSUE/WAIT/RECORD.
- `done` output 1: level, high in DONE until the next `start` or `reset`.
- `result_valid` output 1: one-cycle pulse per captured result.
- `res_intake`, `res_up`, `res_low` output 14 each: captured query and result, held until the next capture.
- `res_gap` output 14: `res_up - res_low`.
- `max_gap` output 14: largest `res_gap` in the current sweep.
- `max_gap_intake` output 14: query value that produced `max_gap`.
- `n_done` output 8: number of results captured in the current sweep.
- `timeout_err` output 1: sweep aborted because the responder did not answer; held until the next `start`.
- `range_err` output 1: sweep aborted because the next query fell outside [MIN_IN, MAX_IN]; held until the next `start`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RECORD, DONE. All outputs are registered.
- **Reset values:** all outputs 0; state IDLE.
- **IDLE/DONE + `start`:**
  - Capture `base`, `step`, `count`.
  - Clear `done`, the error flags, `max_gap`, `max_gap_intake`, and `n_done`.
  - If `count == 0`, go to DONE with no request issued.
  - Otherwise, range-check `base`. If legal, load `Intake = base` and go to ISSUE. If not, set `range_err` and go to DONE.
- **ISSUE:** `give_valid = 1` for exactly this cycle; clear the WAIT counter; go to WAIT. `out_valid` is ignored here. The responder drops `out_valid` on `give_valid`.
- **WAIT:**
  - If `out_valid` is high, capture `UpPrime`/`LowPrime` with the current `Intake` into the `res_*` outputs and go to RECORD.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYC, set `timeout_err` and go to DONE.
- **RECORD:**
  - `result_valid = 1`; `n_done` increments.
  - If `res_gap > max_gap` (strictly greater, so the first occurrence wins ties), update `max_gap` and `max_gap_intake`.
  - If `n_done` (after increment) equals `count`, go to DONE.
  - Otherwise compute `next = Intake + step` in 15 bits. If `next > MAX_IN`, set `range_err` and go to DONE; else set `Intake = next` and go to ISSUE.
- **Arithmetic:** the gap is a 14-bit unsigned subtraction, with `UpPrime > LowPrime` guaranteed by the responder. The `Intake + step` sum is carried in 15 bits so it cannot wrap.
- **Busy behaviour:** `start` while busy is ignored. `Intake` holds its last value in DONE/IDLE.
- **Reset mid-sweep:** immediate return to IDLE with all outputs 0. `give_valid` must never glitch high during or after reset.

## Timing
- `start` sampled at edge E0 → `give_valid` high in cycle E0–E1, i.e. ISSUE is entered directly at E0.
- `out_valid` sampled high at edge Ek → `result_valid` high for cycle Ek–Ek+1.
- The next `give_valid` follows one cycle after RECORD.
- Per-query overhead is 3 cycles plus responder latency.
- `done` rises in the cycle after RECORD of the final query, or after the abort edge.
- Timeout: `timeout_err` is set on the edge where the WAIT counter reaches TIMEOUT_CYC, counted from the first WAIT cycle.

## Test plan
- **Single query:** `base=10`, `count=1`, `step=1`, responder replies (11, 7) after 5 cycles → one `give_valid` pulse with `Intake=10`; `result_valid` with `res_gap=4`; `max_gap=4`, `max_gap_intake=10`; `n_done=1`; `done=1`.
- **Tie handling:** `base=24`, `count=3`, `step=1`, responder returns (29, 23) for each → `Intake` sequence 24, 25, 26; three `result_valid` pulses; `max_gap=6` with `max_gap_intake=24` (first wins the tie).
- **Range abort:** `base=9990`, `step=5`, `count=4` → queries 9990 and 9995 only; `range_err=1`; `n_done=2`; `done=1`; no query issued for 10000.
- **Timeout:** `TIMEOUT_CYC=16`, responder never answers → `timeout_err=1` and `done=1` exactly 16 cycles after entering WAIT; `give_valid` pulsed once.
- **Zero count:** `count=0` → `done=1` the cycle after `start`; `give_valid` never asserted; `n_done=0`.
- **Reset mid-sweep:** assert `reset` mid-WAIT on the second query → all outputs 0 immediately; a new `start` with `base=100`, `count=1` returns (101, 97) with `res_gap=4`.
